garage_door_ctrl_v2: RTL

Parametrised successor to the single-channel garage door FSM, sitting between the door's limit switches, obstruction beam and push-button and the motor driver. It adds known open/closed/stopped states, edge-triggered Activate with stop-and-reverse behaviour, and obstruction reversal while closing. It also adds a travel-timeout fault and an optional auto-close timer. All inputs are already synchronised to `clk` upstream.

---
 rtl/garage_door_pkg.sv | 19 +
 rtl/garage_door_ctrl_v2_door_timer.sv | 27 ++
 rtl/garage_door_ctrl_v2.sv | 130 +++++++++++++
 3 files changed

// File: rtl/garage_door_pkg.sv
// garage_door_pkg: state codes and shared constants for the garage door
// controller.
//   STATE_W : width of the state code exported on state_o
//   state_e : state encoding (codes 7 and above are treated as FAULT)
package garage_door_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_OPEN   = 3'd1,
    ST_CLOSED = 3'd2,
    ST_MV_UP  = 3'd3,
    ST_MV_DN  = 3'd4,
    ST_STOP   = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

endpackage

// File: rtl/garage_door_ctrl_v2_door_timer.sv
// door_timer: saturating up counter shared by the travel and auto-close timers.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable
//   count      : current count, sticks at all-ones
module door_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count up, clearing synchronously and holding at the top value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/garage_door_ctrl_v2.sv
// garage_door_ctrl_v2: garage door controller between the limit switches,
// obstruction beam, push-button and the motor driver.
//   clk, rst : clock, asynchronous active-low reset
//   UP_Max   : fully-open limit switch
//   DN_Max   : fully-closed limit switch
//   Activate : push-button level (rising edge acts)
//   Obstruct : obstruction beam broken
//   UP_M     : drive motor up
//   DN_M     : drive motor down
//   Fault    : latched fault
//   state_o  : current state code
module garage_door_ctrl_v2
  import garage_door_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES     = 1000,
  parameter int unsigned AUTO_CLOSE_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               UP_Max,
  input  logic               DN_Max,
  input  logic               Activate,
  input  logic               Obstruct,
  output logic               UP_M,
  output logic               DN_M,
  output logic               Fault,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned TMR_MAX     = (TRAVEL_CYCLES > AUTO_CLOSE_CYCLES) ?
                                        TRAVEL_CYCLES : AUTO_CLOSE_CYCLES;
  localparam int unsigned TMR_W       = $clog2(TMR_MAX + 1);
  localparam int unsigned TRAVEL_LAST = TRAVEL_CYCLES - 1;
  localparam int unsigned AC_LAST     = (AUTO_CLOSE_CYCLES == 0) ? 0 :
                                        AUTO_CLOSE_CYCLES - 1;
  localparam bit          AC_EN       = (AUTO_CLOSE_CYCLES != 0);

  state_e           state;
  state_e           state_next;
  logic             act_q;
  logic             last_dir;
  logic             act_rise;
  logic             travel_to;
  logic             ac_expire;
  logic             tmr_clr;
  logic [TMR_W-1:0] tmr;

  assign act_rise  = Activate & ~act_q;
  // Timeout is suppressed while either limit switch is reporting.
  assign travel_to = (tmr == TMR_W'(TRAVEL_LAST)) & ~UP_Max & ~DN_Max;
  assign ac_expire = AC_EN & (tmr == TMR_W'(AC_LAST));
  assign state_o   = state;

  // Next-state logic and timer clear.
  always_comb begin
    state_next = state;
    tmr_clr    = 1'b0;
    if ((state != ST_FAULT) && UP_Max && DN_Max) begin
      // Contradictory limit switches: treat as a wiring fault.
      state_next = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (UP_Max)      state_next = ST_OPEN;
          else if (DN_Max) state_next = ST_CLOSED;
          else             state_next = ST_STOP;
        end
        ST_CLOSED: begin
          if (act_rise) state_next = ST_MV_UP;
        end
        ST_OPEN: begin
          if (act_rise)       state_next = ST_MV_DN;
          else if (ac_expire) state_next = ST_MV_DN;
        end
        ST_MV_UP: begin
          if (UP_Max)         state_next = ST_OPEN;
          else if (act_rise)  state_next = ST_STOP;
          else if (travel_to) state_next = ST_FAULT;
        end
        ST_MV_DN: begin
          if (DN_Max)         state_next = ST_CLOSED;
          else if (Obstruct)  state_next = ST_MV_UP;
          else if (act_rise)  state_next = ST_STOP;
          else if (travel_to) state_next = ST_FAULT;
        end
        ST_STOP: begin
          if (act_rise) state_next = last_dir ? ST_MV_DN : ST_MV_UP;
        end
        ST_FAULT: state_next = ST_FAULT;
        default:  state_next = ST_FAULT;
      endcase
    end
    // Any state entry restarts the shared timer; an obstruction in OPEN
    // holds the auto-close count at zero.
    tmr_clr = (state_next != state) | ((state == ST_OPEN) & Obstruct);
  end

  // State, edge detect, direction memory and registered Moore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      act_q    <= 1'b0;
      last_dir <= 1'b0;
      UP_M     <= 1'b0;
      DN_M     <= 1'b0;
      Fault    <= 1'b0;
    end else begin
      state <= state_next;
      act_q <= Activate;
      if (state_next != state) begin
        if (state_next == ST_MV_UP) last_dir <= 1'b1;
        if (state_next == ST_MV_DN) last_dir <= 1'b0;
      end
      UP_M  <= (state_next == ST_MV_UP);
      DN_M  <= (state_next == ST_MV_DN);
      Fault <= (state_next == ST_FAULT);
    end
  end

  door_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst),
    .clr   (tmr_clr),
    .en    (1'b1),
    .count (tmr)
  );

endmodule
